// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle MIPS computer: sequences CPU reset, gates the clock enable
// (free-run / pause / single-step) and detects completion store, hang or cycle-budget timeout.
module cpu_run_ctrl #(
    parameter int             N            = 32,
    parameter int             CYCW         = 16,
    parameter int             RESET_CYCLES = 2,
    parameter int             MAX_CYCLES   = 1000,
    parameter logic [N-1:0]   DONE_ADDR    = N'(12),
    parameter logic [N-1:0]   PASS_VALUE   = N'('h96)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            step,
    input  logic            step_mode,
    input  logic            memwrite,
    input  logic [N-1:0]    dataadr,
    input  logic [N-1:0]    writedata,
    input  logic [N-1:0]    pc,
    output logic            cpu_reset,
    output logic            cpu_clk_en,
    output logic            running,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic            hang,
    output logic [N-1:0]    result,
    output logic [CYCW-1:0] cycle_count
);

    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_RUN, S_PAUSE, S_STEP, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [RCW-1:0]  r_rst_cnt;
    logic [CYCW-1:0] r_cycle_count;
    logic [N-1:0]    r_pc_prev;
    logic            r_prev_en;
    logic            r_pass;
    logic            r_timeout;
    logic            r_hang;
    logic [N-1:0]    r_result;

    logic w_en;
    logic w_load;
    logic w_complete;
    logic w_hang;
    logic w_timeout;
    logic w_event;

    assign w_en       = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_load     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_complete = w_en && memwrite && (dataadr == DONE_ADDR);
    assign w_hang     = w_en && r_prev_en && (pc == r_pc_prev);
    assign w_timeout  = w_en && (r_cycle_count == CYCW'(MAX_CYCLES - 1));
    assign w_event    = w_complete || w_hang || w_timeout;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RST;
            S_RST:   if (r_rst_cnt == '0) w_next_state = step_mode ? S_PAUSE : S_RUN;
            S_RUN: begin
                if (w_event)   w_next_state = S_DONE;
                else if (stop) w_next_state = S_PAUSE;
            end
            S_PAUSE: begin
                if (step)       w_next_state = S_STEP;
                else if (start) w_next_state = S_RUN;
            end
            S_STEP:  w_next_state = w_event ? S_DONE : S_PAUSE;
            S_DONE:  if (start) w_next_state = S_RST;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Counters and result flags; event priority is completion > hang > timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_pc_prev     <= '0;
            r_prev_en     <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_hang        <= 1'b0;
            r_result      <= '0;
        end else if (w_load) begin
            r_rst_cnt     <= RCW'(RESET_CYCLES - 1);
            r_cycle_count <= '0;
            r_prev_en     <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_hang        <= 1'b0;
            r_result      <= '0;
        end else begin
            if ((r_state == S_RST) && (r_rst_cnt != '0))
                r_rst_cnt <= r_rst_cnt - 1'b1;
            r_prev_en <= w_en;
            if (w_en) begin
                r_cycle_count <= r_cycle_count + 1'b1;
                r_pc_prev     <= pc;
                if (w_complete) begin
                    r_result <= writedata;
                    r_pass   <= (writedata == PASS_VALUE);
                end else if (w_hang) begin
                    r_hang <= 1'b1;
                end else if (w_timeout) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cpu_reset   = (r_state == S_IDLE) || (r_state == S_RST);
        cpu_clk_en  = w_en;
        running     = w_en;
        done        = (r_state == S_DONE);
        pass        = r_pass;
        timeout     = r_timeout;
        hang        = r_hang;
        result      = r_result;
        cycle_count = r_cycle_count;
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl: a fake CPU replays a per-enabled-cycle program and a
// program-level model predicts which event ends the run and at which enabled cycle.
module tb_cpu_run_ctrl;

    localparam int          N     = 32;
    localparam int          CYCW  = 16;
    localparam int          RSTC  = 2;
    localparam int          MAXC  = 50;
    localparam logic [31:0] DADDR = 32'd12;
    localparam logic [31:0] PVAL  = 32'h96;

    logic            clk = 1'b0;
    logic            reset, start, stop, step, step_mode, memwrite;
    logic [N-1:0]    dataadr, writedata, pc;
    logic            cpu_reset, cpu_clk_en, running, done, pass, timeout, hang;
    logic [N-1:0]    result;
    logic [CYCW-1:0] cycle_count;

    cpu_run_ctrl #(
        .N(N), .CYCW(CYCW), .RESET_CYCLES(RSTC), .MAX_CYCLES(MAXC),
        .DONE_ADDR(DADDR), .PASS_VALUE(PVAL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
        .step_mode(step_mode), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .pc(pc), .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en),
        .running(running), .done(done), .pass(pass), .timeout(timeout), .hang(hang),
        .result(result), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Program seen by the fake CPU, one entry per enabled cycle.
    logic [31:0] p_pc[64];
    logic [31:0] p_adr[64];
    logic [31:0] p_wd[64];
    bit          p_mw[64];
    int          en_idx;
    int          en_pulses;

    int          exp_count;
    bit          exp_pass, exp_hang, exp_to;
    logic [31:0] exp_result;

    // kind 0: completion at idx; 1: hang at idx; 2: nothing (timeout); 3: completion + hang at idx
    function automatic void gen_prog(input int kind, input int idx, input logic [31:0] val);
        for (int i = 0; i < 64; i++) begin
            int a;
            a = int'($urandom_range(0, 15)) * 4;
            if (a == 12) a = 16;
            p_pc[i]  = 32'h400 + 32'(4 * i);
            p_mw[i]  = 1'($urandom_range(0, 1));
            p_adr[i] = 32'(a);
            p_wd[i]  = $urandom;
        end
        if (idx >= 2) begin
            p_mw[idx/2]  = 1'b1;
            p_adr[idx/2] = 32'd8;
            p_wd[idx/2]  = PVAL;
            p_mw[idx-1]  = 1'b0;
            p_adr[idx-1] = DADDR;
        end
        if (kind == 0 || kind == 3) begin
            p_mw[idx]  = 1'b1;
            p_adr[idx] = DADDR;
            p_wd[idx]  = val;
        end
        if ((kind == 1 || kind == 3) && idx >= 1)
            for (int j = idx - 1; j < 64; j++) p_pc[j] = 32'h1c;
    endfunction

    // First enabled cycle (in a contiguous run) meeting a rule ends the program.
    function automatic void model();
        exp_pass = 0; exp_hang = 0; exp_to = 0; exp_result = '0; exp_count = 0;
        for (int i = 0; i < 64; i++) begin
            if (p_mw[i] && p_adr[i] == DADDR) begin
                exp_result = p_wd[i];
                exp_pass   = (p_wd[i] == PVAL);
                exp_count  = i + 1;
                return;
            end
            if (i > 0 && p_pc[i] == p_pc[i-1]) begin
                exp_hang  = 1;
                exp_count = i + 1;
                return;
            end
            if (i + 1 == MAXC) begin
                exp_to    = 1;
                exp_count = MAXC;
                return;
            end
        end
    endfunction

    // One clock, entered and left at a falling edge; the fake CPU advances on enabled edges.
    task automatic cycle();
        int k;
        bit was_en;
        k         = (en_idx < 64) ? en_idx : 63;
        memwrite  = p_mw[k];
        dataadr   = p_adr[k];
        writedata = p_wd[k];
        pc        = p_pc[k];
        was_en    = cpu_clk_en;
        @(posedge clk);
        @(negedge clk);
        if (was_en) begin
            en_idx++;
            en_pulses++;
        end
        start = 0; stop = 0; step = 0;
    endtask

    task automatic start_and_rst(input string tag);
        int n;
        n = 0;
        en_idx = 0; en_pulses = 0;
        start = 1;
        cycle();
        while (cpu_reset && n < 20) begin
            n++;
            cycle();
        end
        check({tag, "_rst_len"}, 32'(n), 32'(RSTC));
    endtask

    task automatic run_to_done(input string tag, input bit noise);
        int n;
        n = 0;
        while (!done && n < 300) begin
            if (noise) begin
                if ($urandom_range(0, 7) == 0) start = 1;
                if ($urandom_range(0, 7) == 0) step  = 1;
            end
            cycle();
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_outcome(input string tag);
        check({tag, "_pass"},    32'(pass),        32'(exp_pass));
        check({tag, "_timeout"}, 32'(timeout),     32'(exp_to));
        check({tag, "_hang"},    32'(hang),        32'(exp_hang));
        check({tag, "_result"},  result,           exp_result);
        check({tag, "_count"},   32'(cycle_count), 32'(exp_count));
        check({tag, "_pulses"},  32'(en_pulses),   32'(exp_count));
        check({tag, "_clk_en"},  32'(cpu_clk_en),  32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_reset),   32'd0);
        check({tag, "_running"}, 32'(running),     32'd0);
    endtask

    task automatic run_free(input string tag, input bit noise);
        model();
        start_and_rst(tag);
        run_to_done(tag, noise);
        check_outcome(tag);
    endtask

    initial begin
        int k;
        reset = 1; start = 0; stop = 0; step = 0; step_mode = 0;
        memwrite = 0; dataadr = '0; writedata = '0; pc = '0;
        for (int i = 0; i < 64; i++) begin
            p_pc[i] = '0; p_adr[i] = '0; p_wd[i] = '0; p_mw[i] = 0;
        end
        en_idx = 0; en_pulses = 0;

        repeat (2) @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset),   32'd1);
        check("rst_clk_en",    32'(cpu_clk_en),  32'd0);
        check("rst_done",      32'(done),        32'd0);
        check("rst_flags",     {29'd0, pass, timeout, hang}, 32'd0);
        check("rst_result",    result,           32'd0);
        check("rst_count",     32'(cycle_count), 32'd0);
        reset = 0;
        @(negedge clk);

        stop = 1; step = 1;
        cycle();
        cycle();
        check("idle_cpu_reset", 32'(cpu_reset),  32'd1);
        check("idle_clk_en",    32'(cpu_clk_en), 32'd0);

        gen_prog(0, 39, PVAL);
        run_free("pass40", 0);
        stop = 1; cycle();
        step = 1; cycle();
        check("done_hold",       32'(done),        32'd1);
        check("done_hold_count", 32'(cycle_count), 32'(exp_count));
        check("done_hold_en",    32'(cpu_clk_en),  32'd0);

        gen_prog(0, 25, 32'h95);
        run_free("fail95", 0);
        gen_prog(1, 20, '0);
        run_free("hang", 0);
        gen_prog(2, 0, '0);
        run_free("timeout", 0);
        gen_prog(0, MAXC - 1, PVAL);
        run_free("cmp_vs_to", 0);
        gen_prog(3, 15, 32'h1234);
        run_free("cmp_vs_hang", 0);

        for (int r = 0; r < 10; r++) begin
            logic [31:0] v;
            v = ($urandom_range(0, 1) == 1) ? PVAL : $urandom;
            gen_prog(int'($urandom_range(0, 3)), int'($urandom_range(1, 55)), v);
            run_free($sformatf("rnd%0d", r), 1);
        end

        gen_prog(0, 30, PVAL);
        model();
        start_and_rst("pause");
        k = int'($urandom_range(3, 20));
        repeat (k - 1) cycle();
        stop = 1;
        cycle();
        check("pause_count",   32'(cycle_count), 32'(k));
        check("pause_running", 32'(running),     32'd0);
        repeat ($urandom_range(2, 5)) cycle();
        check("pause_hold",    32'(cycle_count), 32'(k));
        check("pause_clk_en",  32'(cpu_clk_en),  32'd0);
        start = 1;
        cycle();
        check("resume_running", 32'(running), 32'd1);
        run_to_done("pause", 0);
        check_outcome("pause");

        step_mode = 1;
        gen_prog(0, 20, PVAL);
        model();
        start_and_rst("step");
        step_mode = 0;
        check("step_paused", 32'(running), 32'd0);
        repeat (3) cycle();
        check("step_idle_count", 32'(cycle_count), 32'd0);
        for (int s = 0; s < 3; s++) begin
            step = 1;
            cycle();
            repeat ($urandom_range(1, 3)) cycle();
        end
        check("step_pulses",  32'(en_pulses),   32'd3);
        check("step_count",   32'(cycle_count), 32'd3);
        check("step_running", 32'(running),     32'd0);
        step = 1; start = 1;
        cycle();
        check("step_start_in_step", 32'(running), 32'd1);
        cycle();
        check("step_start_back", 32'(running),     32'd0);
        check("step_start_cnt",  32'(cycle_count), 32'd4);
        start = 1;
        cycle();
        check("step_to_run", 32'(running), 32'd1);
        run_to_done("step", 0);
        check_outcome("step");

        gen_prog(0, 40, PVAL);
        model();
        start_and_rst("midrst");
        repeat (10) cycle();
        #2 reset = 1;
        #1;
        check("midrst_cpu_reset", 32'(cpu_reset),   32'd1);
        check("midrst_clk_en",    32'(cpu_clk_en),  32'd0);
        check("midrst_count",     32'(cycle_count), 32'd0);
        check("midrst_running",   32'(running),     32'd0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        start_and_rst("rerun");
        run_to_done("rerun", 0);
        check_outcome("rerun");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
